instr_fetch_unit: RTL and testbench

//  Fetch stage sitting directly upstream of control_unit. It owns the PC and issues in-order requests to

---
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner, in-order imem requester and registered decode FIFO
//               with redirect flush. Optional macro IFU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_plus4,
  output logic              fetch_fault
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic              w_fault;
  logic [ADDR_W-1:0] w_target;
  logic [CNT_W:0]    w_occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign w_target = redirect_pc;

  always_comb begin
    fault_d = fault_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign w_fault = fault_q;
`else
  logic w_unused_pc_lsbs;

  assign w_target         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_fault          = 1'b0;
`endif

  assign fetch_fault = w_fault;

  assign instr_valid = (count_q != '0);
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;

  // A slot being popped this cycle is credited immediately so a 1-cycle imem
  // can sustain one instruction per cycle.
  assign w_occupancy    = {1'b0, inflight_q} + {1'b0, count_q} - (CNT_W + 1)'(w_pop);
  assign imem_req_valid = !reset && (w_occupancy < DEPTH_C) && !redirect_valid && !w_fault;
  assign imem_req_addr  = pc_q;
  assign w_accept       = imem_req_valid && imem_req_ready;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    w_push     = 1'b0;
    inflight_d = inflight_q + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
    // Every response still owed at a redirect belongs to the old stream.
    if (redirect_valid) begin
      pc_d       = w_target;
      rsp_pc_d   = w_target;
      drop_cnt_d = inflight_d;
    end else begin
      if (w_accept) pc_d = pc_q + ADDR_W'(4);
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else begin
          w_push   = 1'b1;
          rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        end
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(w_push && !w_pop && (count_q == CNT_W'(DEPTH))));
  end

  assign instr          = fifo_data_q[rd_ptr_q];
  assign op             = instr[31:26];
  assign funct          = instr[5:0];
  assign instr_pc       = fifo_pc_q[rd_ptr_q];
  assign instr_pc_plus4 = instr_pc + ADDR_W'(4);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: directed tests of instr_fetch_unit against a small
// in-order imem model with programmable latency.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_fault;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } req_t;
  req_t pq[$];

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op(op), .funct(funct), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // imem model: decides requests and responses 1 time unit after negedge,
  // after the scenario tasks have driven their inputs for the cycle.
  always begin
    req_t r;
    @(negedge clk);
    #1;
    cyc = cyc + 1;
    if (reset) pq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pq[0].a);
      void'(pq.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      r.a   = imem_req_addr;
      r.due = cyc + lat;
      pq.push_back(r);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    @(negedge clk); #2;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_fault: got %b expected 0", fetch_fault); end
    @(negedge clk);
    reset = 1'b0;
    #2;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      begin tests_failed++; $display("FAIL release_first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); end
  endtask

  // Continues directly from test_reset: address k*4 is requested in cycle k
  // after release and becomes the FIFO head two cycles later.
  task automatic test_stream();
    logic [31:0] exp_pc, exp_w;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #2;
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k))
        begin tests_failed++; $display("FAIL stream_req[%0d]: got v=%b a=%h expected v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(4 * k)); end
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        exp_w  = mem_word(exp_pc);
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_pc_plus4 !== exp_pc + 32'd4 || instr !== exp_w)
          begin tests_failed++; $display("FAIL stream_head[%0d]: got v=%b pc=%h pc4=%h i=%h expected pc=%h i=%h", k, instr_valid, instr_pc, instr_pc_plus4, instr, exp_pc, exp_w); end
        tests_run++;
        if (op !== exp_w[31:26] || funct !== exp_w[5:0])
          begin tests_failed++; $display("FAIL stream_opfunct[%0d]: got op=%h funct=%h expected op=%h funct=%h", k, op, funct, exp_w[31:26], exp_w[5:0]); end
      end else begin
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_first_empty: got %b expected 0", instr_valid); end
      end
    end
  endtask

  // Continues from test_stream: head 0x14 buffered with 0x18 in flight.
  task automatic test_backpressure();
    logic [31:0] exp_pc;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #2;
      tests_run++;
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_no_req[%0d]: got %b expected 0", k, imem_req_valid); end
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr !== mem_word(32'h14))
        begin tests_failed++; $display("FAIL stall_head_held[%0d]: got v=%b pc=%h i=%h expected pc=00000014", k, instr_valid, instr_pc, instr); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #2;
      exp_pc = 32'h14 + 32'(4 * k);
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc))
        begin tests_failed++; $display("FAIL resume_head[%0d]: got v=%b pc=%h expected pc=%h", k, instr_valid, instr_pc, exp_pc); end
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1C + 32'(4 * k))
        begin tests_failed++; $display("FAIL resume_req[%0d]: got v=%b a=%h expected a=%h", k, imem_req_valid, imem_req_addr, 32'h1C + 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] exp_pc;
    bit seen_req = 1'b0;
    int n_instr = 0;
    lat = 3;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #2;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_cycle_no_req: got %b expected 0", imem_req_valid); end
    for (int c = 0; c < 20 && n_instr < 2; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      if (!seen_req && imem_req_valid === 1'b1) begin
        seen_req = 1'b1;
        tests_run++;
        if (imem_req_addr !== 32'h40) begin tests_failed++; $display("FAIL redir_first_req: got %h expected 00000040", imem_req_addr); end
      end
      if (instr_valid === 1'b1) begin
        exp_pc = 32'h40 + 32'(4 * n_instr);
        tests_run++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc))
          begin tests_failed++; $display("FAIL redir_head[%0d]: got pc=%h i=%h expected pc=%h i=%h", n_instr, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
        n_instr++;
      end
    end
    tests_run++;
    if (n_instr != 2 || !seen_req) begin tests_failed++; $display("FAIL redir_timeout: got instrs=%0d req_seen=%0d expected 2 and 1", n_instr, seen_req); end
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #2;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_no_req: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_flushed: got %b expected 0", instr_valid); end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
      begin tests_failed++; $display("FAIL collide_req_target: got v=%b a=%h expected a=00000100", imem_req_valid, imem_req_addr); end
    @(negedge clk); #2;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_req_addr !== 32'h104)
      begin tests_failed++; $display("FAIL collide_next: got v=%b a=%h expected v=0 a=00000104", instr_valid, imem_req_addr); end
    @(negedge clk); #2;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_pc_plus4 !== 32'h104 || instr !== mem_word(32'h100))
      begin tests_failed++; $display("FAIL collide_head: got v=%b pc=%h pc4=%h expected pc=00000100 pc4=00000104", instr_valid, instr_pc, instr_pc_plus4); end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
      begin tests_failed++; $display("FAIL wrap_req_top: got v=%b a=%h expected a=fffffffc", imem_req_valid, imem_req_addr); end
    @(negedge clk); #2;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      begin tests_failed++; $display("FAIL wrap_req_zero: got v=%b a=%h expected a=00000000", imem_req_valid, imem_req_addr); end
    @(negedge clk); #2;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0)
      begin tests_failed++; $display("FAIL wrap_head: got v=%b pc=%h pc4=%h expected pc=fffffffc pc4=00000000", instr_valid, instr_pc, instr_pc_plus4); end
    @(negedge clk); #2;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0))
      begin tests_failed++; $display("FAIL wrap_head_next: got v=%b pc=%h expected pc=00000000", instr_valid, instr_pc); end
  endtask

  task automatic test_misalign();
    lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
`ifdef IFU_MISALIGN_TRAP_EN
    tests_run++;
    if (fetch_fault !== 1'b1) begin tests_failed++; $display("FAIL misalign_fault: got %b expected 1", fetch_fault); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL misalign_no_req[%0d]: got %b expected 0", k, imem_req_valid); end
      @(negedge clk); #2;
    end
    reset = 1'b1;
    @(negedge clk); #2;
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL misalign_reset_clears: got %b expected 0", fetch_fault); end
    reset = 1'b0;
`else
    tests_run++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40)
      begin tests_failed++; $display("FAIL misalign_forced: got f=%b v=%b a=%h expected f=0 v=1 a=00000040", fetch_fault, imem_req_valid, imem_req_addr); end
    repeat (2) @(negedge clk);
    #2;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || fetch_fault !== 1'b0)
      begin tests_failed++; $display("FAIL misalign_resume_head: got v=%b pc=%h f=%b expected v=1 pc=00000040 f=0", instr_valid, instr_pc, fetch_fault); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
